pad_bidir_ctrl: RTL and testbench

PAD_BIDIR_CTRL -- requirements
Module: pad_bidir_ctrl

---
 rtl/pad_bidir_ctrl.sv | 133 +++++++++++++
 tb/tb_pad_bidir_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pad_bidir_ctrl.sv
// Bidirectional pad controller: direction FSM with dead-time turnaround,
// registered pad controls, and a multi-stage synchronizer on the pad input.
module pad_bidir_ctrl #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dir_out,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  input  logic [1:0]       cfg_ds,
  input  logic             cfg_sr,
  output logic [WIDTH-1:0] pad_a,
  input  logic [WIDTH-1:0] pad_y,
  output logic [WIDTH-1:0] pad_oe,
  output logic [WIDTH-1:0] pad_ie,
  output logic             pad_ds0,
  output logic             pad_ds1,
  output logic             pad_sr
);

  typedef enum logic [1:0] {
    ST_IN       = 2'd0,
    ST_TURN_OUT = 2'd1,
    ST_OUT      = 2'd2,
    ST_TURN_IN  = 2'd3
  } state_t;

  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);
  localparam logic [2:0] FILL_FULL = 3'(SYNC_STAGES);

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [2:0]       fill_reg;
  logic [WIDTH-1:0] sync_reg [SYNC_STAGES];

  // Next-state logic; dir_out is only sampled in the two stable states.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IN: begin
        if (dir_out) begin
          state_next = ST_TURN_OUT;
          cnt_next   = TURN_LOAD;
        end
      end
      ST_TURN_OUT: begin
        if (cnt_reg == 4'd0) state_next = ST_OUT;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      ST_OUT: begin
        if (!dir_out) begin
          state_next = ST_TURN_IN;
          cnt_next   = TURN_LOAD;
        end
      end
      ST_TURN_IN: begin
        if (cnt_reg == 4'd0) state_next = ST_IN;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      default: begin
        state_next = ST_IN;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // pad_oe/pad_ie follow state_next so they switch on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IN;
      cnt_reg   <= 4'd0;
      pad_oe    <= '0;
      pad_ie    <= '1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pad_oe    <= {WIDTH{state_next == ST_OUT}};
      pad_ie    <= {WIDTH{state_next == ST_IN}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_a <= '0;
    end else if (state_reg == ST_OUT && tx_valid) begin
      pad_a <= tx_data;
    end
  end

  // Drive-strength and slew settings are frozen while actively driving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_ds0 <= 1'b0;
      pad_ds1 <= 1'b0;
      pad_sr  <= 1'b0;
    end else if (state_reg != ST_OUT) begin
      pad_ds0 <= cfg_ds[0];
      pad_ds1 <= cfg_ds[1];
      pad_sr  <= cfg_sr;
    end
  end

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk or posedge rst) begin
        if (rst)          sync_reg[gi] <= '0;
        else if (gi == 0) sync_reg[gi] <= pad_y;
        else              sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
      end
    end
  endgenerate

  // Counts clocks spent in IN so rx_valid waits for the chain to refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        fill_reg <= 3'd0;
    else if (state_reg != ST_IN)    fill_reg <= 3'd0;
    else if (fill_reg != FILL_FULL) fill_reg <= fill_reg + 3'd1;
  end

  assign rx_data  = sync_reg[SYNC_STAGES-1];
  assign rx_valid = (state_reg == ST_IN) && (fill_reg == FILL_FULL);
  assign tx_ready = (state_reg == ST_OUT);
  assign busy     = (state_reg == ST_TURN_OUT) || (state_reg == ST_TURN_IN);

endmodule

// File: tb/tb_pad_bidir_ctrl.sv
// Scoreboard bench for pad_bidir_ctrl: expectations are queued with each
// stimulus step and checked against the outputs one clock later.
module tb_pad_bidir_ctrl;

  localparam int W = 8;

  localparam int S_OE = 0, S_IE = 1, S_A = 2, S_DS0 = 3, S_DS1 = 4,
                 S_SR = 5, S_TXR = 6, S_RXV = 7, S_RXD = 8, S_BUSY = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic         dir_out, tx_valid, tx_ready;
  logic [W-1:0] tx_data, rx_data, pad_a, pad_y, pad_oe, pad_ie;
  logic         rx_valid, busy, cfg_sr, pad_ds0, pad_ds1, pad_sr;
  logic [1:0]   cfg_ds;

  typedef struct {
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;

  pad_bidir_ctrl #(.WIDTH(W), .TURN_CYCLES(2), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .dir_out(dir_out), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_data(tx_data), .rx_valid(rx_valid),
    .rx_data(rx_data), .busy(busy), .cfg_ds(cfg_ds), .cfg_sr(cfg_sr),
    .pad_a(pad_a), .pad_y(pad_y), .pad_oe(pad_oe), .pad_ie(pad_ie),
    .pad_ds0(pad_ds0), .pad_ds1(pad_ds1), .pad_sr(pad_sr)
  );

  always #5 clk = ~clk;

  function automatic string sig_name(int s);
    case (s)
      S_OE:    return "pad_oe";
      S_IE:    return "pad_ie";
      S_A:     return "pad_a";
      S_DS0:   return "pad_ds0";
      S_DS1:   return "pad_ds1";
      S_SR:    return "pad_sr";
      S_TXR:   return "tx_ready";
      S_RXV:   return "rx_valid";
      S_RXD:   return "rx_data";
      default: return "busy";
    endcase
  endfunction

  function automatic logic [31:0] observe(int s);
    case (s)
      S_OE:    return 32'(pad_oe);
      S_IE:    return 32'(pad_ie);
      S_A:     return 32'(pad_a);
      S_DS0:   return 32'(pad_ds0);
      S_DS1:   return 32'(pad_ds1);
      S_SR:    return 32'(pad_sr);
      S_TXR:   return 32'(tx_ready);
      S_RXV:   return 32'(rx_valid);
      S_RXD:   return 32'(rx_data);
      default: return 32'(busy);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input int s, input logic [31:0] v);
    exp_t e;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(sig_name(e.sig), observe(e.sig), e.val);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; dir_out = 1'b0; tx_valid = 1'b0; tx_data = '0;
    cfg_ds = 2'b00; cfg_sr = 1'b0; pad_y = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    push(S_OE, 0); push(S_IE, 8'hFF); push(S_A, 0); push(S_DS0, 0); push(S_DS1, 0);
    push(S_SR, 0); push(S_TXR, 0); push(S_RXV, 0); push(S_BUSY, 0); push(S_RXD, 0);
    drain();

    // Reset release: synchronizer refills in two clocks.
    rst = 1'b0;
    push(S_RXV, 0); cyc();
    push(S_RXV, 1); push(S_RXD, 8'hA5); cyc();
    $display("reset release: rx_data=%h rx_valid=%b", rx_data, rx_valid);

    pad_y = 8'h77;
    push(S_RXD, 8'hA5); cyc();
    push(S_RXD, 8'h77); cyc();
    $display("pad_y change: rx_data=%h", rx_data);

    // IN -> TURN_OUT; dir_out dropping mid-turnaround must be ignored.
    dir_out = 1'b1;
    push(S_OE, 0); push(S_IE, 0); push(S_BUSY, 1); push(S_TXR, 0); push(S_RXV, 0); cyc();
    dir_out = 1'b0;
    push(S_OE, 0); push(S_IE, 0); push(S_BUSY, 1); cyc();
    push(S_OE, 8'hFF); push(S_IE, 0); push(S_BUSY, 0); push(S_TXR, 1); cyc();
    $display("turn out: pad_oe=%h tx_ready=%b", pad_oe, tx_ready);
    dir_out = 1'b1;

    // OUT: word accepted, cfg change deferred.
    tx_valid = 1'b1; tx_data = 8'h3C; cfg_ds = 2'b11; cfg_sr = 1'b1;
    push(S_A, 8'h3C); push(S_DS0, 0); push(S_DS1, 0); push(S_SR, 0); push(S_OE, 8'hFF); cyc();
    tx_valid = 1'b0; tx_data = 8'hFF;
    push(S_A, 8'h3C); push(S_DS1, 0); push(S_TXR, 1); cyc();
    $display("out tx: pad_a=%h ds=%b%b", pad_a, pad_ds1, pad_ds0);

    // Simultaneous tx_valid and dir_out=0.
    tx_valid = 1'b1; tx_data = 8'h5A; dir_out = 1'b0;
    push(S_A, 8'h5A); push(S_OE, 0); push(S_IE, 0); push(S_BUSY, 1);
    push(S_TXR, 0); push(S_DS1, 0); push(S_DS0, 0); cyc();
    tx_valid = 1'b0; tx_data = '0;
    push(S_BUSY, 1); push(S_DS1, 1); push(S_DS0, 1); push(S_SR, 1); cyc();
    push(S_IE, 8'hFF); push(S_BUSY, 0); push(S_RXV, 0); push(S_OE, 0); cyc();
    push(S_RXV, 0); cyc();
    push(S_RXV, 1); push(S_RXD, 8'h77); push(S_A, 8'h5A); cyc();
    $display("turn in: pad_a=%h rx_valid=%b", pad_a, rx_valid);

    // Config in IN applies on the next clock.
    cfg_ds = 2'b01; cfg_sr = 1'b0;
    push(S_DS1, 0); push(S_DS0, 1); push(S_SR, 0); cyc();
    $display("cfg in IN: ds=%b%b sr=%b", pad_ds1, pad_ds0, pad_sr);

    // Reset pulse during TURN_OUT acts without a clock edge.
    dir_out = 1'b1;
    push(S_BUSY, 1); cyc();
    #2 rst = 1'b1;
    #1;
    push(S_OE, 0); push(S_IE, 8'hFF); push(S_BUSY, 0); push(S_A, 0); push(S_DS0, 0);
    drain();
    $display("reset in TURN_OUT: pad_oe=%h pad_ie=%h", pad_oe, pad_ie);

    // Reset pulse while driving in OUT.
    @(negedge clk) rst = 1'b0;
    push(S_BUSY, 1); cyc();
    push(S_BUSY, 1); cyc();
    push(S_OE, 8'hFF); push(S_TXR, 1); cyc();
    #2 rst = 1'b1;
    #1;
    push(S_OE, 0); push(S_IE, 8'hFF); push(S_TXR, 0);
    drain();
    $display("reset in OUT: pad_oe=%h tx_ready=%b", pad_oe, tx_ready);

    @(negedge clk) rst = 1'b0;
    dir_out = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
